// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: aluc codes, MIPS opcode/funct
// values, and the issue-beat payload that flows through the skid buffer.
package alu_pkg;

  localparam int XLEN_P = 32;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;

  typedef struct packed {
    logic [XLEN_P-1:0] a;
    logic [XLEN_P-1:0] b;
    logic [3:0]        aluc;
    logic [4:0]        dest;
    logic              wen;
    logic              illegal;
  } issue_beat_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  function automatic logic [XLEN_P-1:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: upstream instruction beat in, ALU operand beat out.
// Optional ALU_ISSUE_ILLEGAL_EN adds out_illegal and err_sticky.
interface alu_issue_stage_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_rs_val;
  logic [XLEN-1:0] in_rt_val;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [3:0]      out_aluc;
  logic [4:0]      out_dest;
  logic            out_wen;
`ifdef ALU_ISSUE_ILLEGAL_EN
  logic            out_illegal;
  logic            err_sticky;
`endif

  modport slave (
    input  in_valid, in_instr, in_rs_val, in_rt_val, out_ready,
`ifdef ALU_ISSUE_ILLEGAL_EN
    output out_illegal, err_sticky,
`endif
    output in_ready, out_valid, out_a, out_b, out_aluc, out_dest, out_wen
  );

  modport master (
    output in_valid, in_instr, in_rs_val, in_rt_val, out_ready,
`ifdef ALU_ISSUE_ILLEGAL_EN
    input  out_illegal, err_sticky,
`endif
    input  in_ready, out_valid, out_a, out_b, out_aluc, out_dest, out_wen
  );
endinterface

// File: rtl/alu_issue_decode.sv
// Combinational decode of a MIPS ALU instruction plus its register values
// into the ALU issue beat (aluc, operands, destination, write enable).
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0]       instr_i,
  input  logic [XLEN_P-1:0] rs_val_i,
  input  logic [XLEN_P-1:0] rt_val_i,
  output issue_beat_t       beat_o
);

  logic [5:0]  opcode;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic        supported;
  logic [4:0]  dest_idx;
  logic        unused_rs_idx;

  assign opcode = instr_i[31:26];
  assign rt_idx = instr_i[20:16];
  assign rd_idx = instr_i[15:11];
  assign shamt  = instr_i[10:6];
  assign funct  = instr_i[5:0];
  assign imm16  = instr_i[15:0];
  // rs arrives already read out as rs_val_i; its index field is not needed here.
  assign unused_rs_idx = ^instr_i[25:21];

  always_comb begin
    beat_o      = '0;
    beat_o.a    = rs_val_i;
    beat_o.b    = rt_val_i;
    beat_o.aluc = ALUC_ADD;
    supported   = 1'b0;
    dest_idx    = '0;
    case (opcode)
      OP_RTYPE: begin
        supported = 1'b1;
        dest_idx  = rd_idx;
        case (funct)
          F_ADD, F_ADDU: beat_o.aluc = ALUC_ADD;
          F_SUB, F_SUBU: beat_o.aluc = ALUC_SUB;
          F_AND:         beat_o.aluc = ALUC_AND;
          F_OR:          beat_o.aluc = ALUC_OR;
          F_XOR:         beat_o.aluc = ALUC_XOR;
          F_SLL: begin beat_o.aluc = ALUC_SLL; beat_o.a = {27'b0, shamt}; end
          F_SRL: begin beat_o.aluc = ALUC_SRL; beat_o.a = {27'b0, shamt}; end
          F_SRA: begin beat_o.aluc = ALUC_SRA; beat_o.a = {27'b0, shamt}; end
          F_SLLV:        beat_o.aluc = ALUC_SLL;
          F_SRLV:        beat_o.aluc = ALUC_SRL;
          F_SRAV:        beat_o.aluc = ALUC_SRA;
          default:       supported   = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        supported = 1'b1; dest_idx = rt_idx;
        beat_o.aluc = ALUC_ADD; beat_o.b = sext16(imm16);
      end
      OP_ANDI: begin
        supported = 1'b1; dest_idx = rt_idx;
        beat_o.aluc = ALUC_AND; beat_o.b = {16'b0, imm16};
      end
      OP_ORI: begin
        supported = 1'b1; dest_idx = rt_idx;
        beat_o.aluc = ALUC_OR; beat_o.b = {16'b0, imm16};
      end
      OP_XORI: begin
        supported = 1'b1; dest_idx = rt_idx;
        beat_o.aluc = ALUC_XOR; beat_o.b = {16'b0, imm16};
      end
      OP_LUI: begin
        // The ALU does the shift-by-16; issue hands it the raw immediate.
        supported = 1'b1; dest_idx = rt_idx;
        beat_o.aluc = ALUC_LUI; beat_o.b = {16'b0, imm16};
      end
      default: supported = 1'b0;
    endcase
    beat_o.dest    = supported ? dest_idx : 5'd0;
    beat_o.wen     = supported && (dest_idx != 5'd0);
    beat_o.illegal = !supported;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode plus two-entry registered skid buffer with
// valid/ready on both sides. Optional feature macro: ALU_ISSUE_ILLEGAL_EN.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  alu_issue_stage_if.slave bus
);

  if (XLEN != 32) begin : g_xlen_check
    $error("alu_issue_stage: XLEN must be 32");
  end

  skid_state_e state_q, state_d;
  issue_beat_t main_q, main_d;
  issue_beat_t skid_q, skid_d;
  issue_beat_t dec_beat;
  logic        in_acc;
  logic        out_acc;

  alu_issue_decode u_decode (
    .instr_i  (bus.in_instr),
    .rs_val_i (bus.in_rs_val),
    .rt_val_i (bus.in_rt_val),
    .beat_o   (dec_beat)
  );

  // in_ready comes only from registered state, never from out_ready.
  assign in_acc  = bus.in_valid && (state_q != SKID_TWO);
  assign out_acc = (state_q != SKID_EMPTY) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      SKID_EMPTY: begin
        if (in_acc) begin
          state_d = SKID_ONE;
          main_d  = dec_beat;
        end
      end
      SKID_ONE: begin
        if (in_acc && out_acc) begin
          main_d = dec_beat;
        end else if (in_acc) begin
          state_d = SKID_TWO;
          skid_d  = dec_beat;
        end else if (out_acc) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        if (out_acc) begin
          state_d = SKID_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SKID_EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  // The skid entry is only ever read after being written, so it needs no reset.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign bus.in_ready  = (state_q != SKID_TWO);
  assign bus.out_valid = (state_q != SKID_EMPTY);
  assign bus.out_a     = main_q.a;
  assign bus.out_b     = main_q.b;
  assign bus.out_aluc  = main_q.aluc;
  assign bus.out_dest  = main_q.dest;
  assign bus.out_wen   = main_q.wen;

`ifdef ALU_ISSUE_ILLEGAL_EN
  logic err_sticky_q, err_sticky_d;

  assign err_sticky_d = err_sticky_q || (out_acc && main_q.illegal);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_sticky_q <= 1'b0;
    else        err_sticky_q <= err_sticky_d;
  end

  assign bus.out_illegal = main_q.illegal;
  assign bus.err_sticky  = err_sticky_q;
`else
  logic unused_illegal;
  assign unused_illegal = main_q.illegal;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed literal cases plus randomized traffic
// against a queue-based reference model; honours ALU_ISSUE_ILLEGAL_EN.
module tb_alu_issue_stage;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_issue_stage_if #(.XLEN(32)) bus ();

  alu_issue_stage #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluc;
    logic [4:0]  dest;
    logic        wen;
    logic        ill;
  } exp_t;

  exp_t q[$];
  logic model_sticky;

  // Spec tables: funct -> aluc for R-type, opcode -> aluc for I-type.
  int r_aluc[int];
  int i_aluc[int];

  initial begin
    r_aluc[32] = 0;  r_aluc[33] = 0;  r_aluc[34] = 4;  r_aluc[35] = 4;
    r_aluc[36] = 1;  r_aluc[37] = 5;  r_aluc[38] = 2;
    r_aluc[0]  = 3;  r_aluc[2]  = 7;  r_aluc[3]  = 15;
    r_aluc[4]  = 3;  r_aluc[6]  = 7;  r_aluc[7]  = 15;
    i_aluc[8]  = 0;  i_aluc[9]  = 0;  i_aluc[12] = 1;
    i_aluc[13] = 5;  i_aluc[14] = 2;  i_aluc[15] = 6;
  end

  function automatic exp_t ref_beat(input logic [31:0] instr, input logic [31:0] rs,
                                    input logic [31:0] rt);
    exp_t e;
    int op, fn, imm, dst;
    bit ok;
    op  = int'(instr >> 26);
    fn  = int'(instr % 64);
    imm = int'(instr % 65536);
    e.a = rs; e.b = rt; e.aluc = 4'd0; dst = 0; ok = 0;
    if (op == 0 && r_aluc.exists(fn)) begin
      ok = 1;
      e.aluc = 4'(r_aluc[fn]);
      dst = int'((instr >> 11) % 32);
      if (fn < 4) e.a = (instr >> 6) % 32;
    end else if (op != 0 && i_aluc.exists(op)) begin
      ok = 1;
      e.aluc = 4'(i_aluc[op]);
      dst = int'((instr >> 16) % 32);
      if (op == 8 || op == 9) e.b = (imm >= 32768) ? 32'(imm) - 32'd65536 : 32'(imm);
      else                    e.b = 32'(imm);
    end
    e.dest = ok ? 5'(dst) : 5'd0;
    e.wen  = ok && (dst != 0);
    e.ill  = !ok;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // Reference model: a FIFO of at most two beats.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      model_sticky <= 1'b0;
    end else begin
      bit do_pop, do_push;
      do_pop  = (q.size() > 0) && bus.out_ready;
      do_push = (q.size() < 2) && bus.in_valid;
      if (do_pop) begin
        if (q[0].ill) model_sticky <= 1'b1;
        void'(q.pop_front());
      end
      if (do_push) q.push_back(ref_beat(bus.in_instr, bus.in_rs_val, bus.in_rt_val));
    end
  end

  // Cycle compare of DUT against model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst out_valid", bus.out_valid, 0);
      chk("rst in_ready", bus.in_ready, 1);
      chk("rst out_a", bus.out_a, 0);
      chk("rst out_b", bus.out_b, 0);
      chk("rst out_aluc", bus.out_aluc, 0);
      chk("rst out_dest", bus.out_dest, 0);
      chk("rst out_wen", bus.out_wen, 0);
`ifdef ALU_ISSUE_ILLEGAL_EN
      chk("rst out_illegal", bus.out_illegal, 0);
      chk("rst err_sticky", bus.err_sticky, 0);
`endif
    end else begin
      chk("in_ready", bus.in_ready, (q.size() < 2) ? 1 : 0);
      chk("out_valid", bus.out_valid, (q.size() > 0) ? 1 : 0);
      if (q.size() > 0) begin
        chk("out_a", bus.out_a, q[0].a);
        chk("out_b", bus.out_b, q[0].b);
        chk("out_aluc", bus.out_aluc, q[0].aluc);
        chk("out_dest", bus.out_dest, q[0].dest);
        chk("out_wen", bus.out_wen, q[0].wen);
`ifdef ALU_ISSUE_ILLEGAL_EN
        chk("out_illegal", bus.out_illegal, q[0].ill);
`endif
      end
`ifdef ALU_ISSUE_ILLEGAL_EN
      chk("err_sticky", bus.err_sticky, model_sticky);
`endif
    end
  end

  task automatic drive(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
    bus.in_valid  = 1'b1;
    bus.in_instr  = instr;
    bus.in_rs_val = rs;
    bus.in_rt_val = rt;
  endtask

  task automatic issue1(input string nm, input logic [31:0] instr, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] ea, input logic [31:0] eb,
                        input logic [3:0] ealuc, input logic [4:0] edest, input logic ewen);
    @(negedge clk); #1;
    drive(instr, rs, rt);
    @(negedge clk);
    chk({nm, " valid"}, bus.out_valid, 1);
    chk({nm, " a"}, bus.out_a, ea);
    chk({nm, " b"}, bus.out_b, eb);
    chk({nm, " aluc"}, bus.out_aluc, ealuc);
    chk({nm, " dest"}, bus.out_dest, edest);
    chk({nm, " wen"}, bus.out_wen, ewen);
    #1 bus.in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] rf[15];
    logic [5:0] ro[7];
    logic [31:0] w;
    rf = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd0, 6'd2, 6'd3,
           6'd4, 6'd6, 6'd7, 6'd42, 6'd1};
    ro = '{6'd8, 6'd9, 6'd12, 6'd13, 6'd14, 6'd15, 6'd10};
    w = $urandom;
    if ($urandom_range(0, 1) == 1) begin
      w[31:26] = 6'd0;
      w[5:0]   = rf[$urandom_range(0, 14)];
      if ($urandom_range(0, 7) == 0) w[15:11] = 5'd0;
    end else begin
      w[31:26] = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ro[$urandom_range(0, 6)];
      if ($urandom_range(0, 7) == 0) w[20:16] = 5'd0;
    end
    return w;
  endfunction

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_rs_val = '0;
    bus.in_rt_val = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset in_ready", bus.in_ready, 1);
    #1 rst_n = 1'b1;

    issue1("add",  32'h00221820, 32'd5, 32'd7, 32'd5, 32'd7, 4'b0000, 5'd3, 1'b1);
    issue1("addi", 32'h2004FFFF, 32'd0, 32'd9, 32'd0, 32'hFFFFFFFF, 4'b0000, 5'd4, 1'b1);
    issue1("ori",  32'h3425FFFF, 32'h11, 32'd0, 32'h11, 32'h0000FFFF, 4'b0101, 5'd5, 1'b1);
    issue1("lui",  32'h3C061234, 32'd0, 32'd0, 32'd0, 32'h00001234, 4'b0110, 5'd6, 1'b1);
    issue1("sra",  32'h00062903, 32'h99, 32'h80000000, 32'd4, 32'h80000000, 4'b1111, 5'd5, 1'b1);
    issue1("srav", 32'h01283807, 32'h25, 32'h1234, 32'h25, 32'h1234, 4'b1111, 5'd7, 1'b1);
    issue1("add0", 32'h00220020, 32'd1, 32'd2, 32'd1, 32'd2, 4'b0000, 5'd0, 1'b0);
`ifdef ALU_ISSUE_ILLEGAL_EN
    chk("add0 illegal", bus.out_illegal, 0);
`endif
    issue1("slt",  32'h0022182A, 32'h3, 32'h4, 32'h3, 32'h4, 4'b0000, 5'd0, 1'b0);
`ifdef ALU_ISSUE_ILLEGAL_EN
    chk("slt illegal", bus.out_illegal, 1);
    @(negedge clk);
    chk("slt sticky", bus.err_sticky, 1);
    issue1("sub", 32'h00221822, 32'd9, 32'd4, 32'd9, 32'd4, 4'b0100, 5'd3, 1'b1);
    chk("sticky holds", bus.err_sticky, 1);
`endif

    // Skid: A, B, C back to back with out_ready low for three edges.
    @(negedge clk); #1;
    bus.out_ready = 1'b0;
    drive(32'h00221820, 32'hA, 32'd1);
    @(negedge clk);
    chk("skid A main", bus.out_a, 32'hA);
    #1 drive(32'h00221820, 32'hB, 32'd1);
    @(negedge clk);
    chk("skid full ready", bus.in_ready, 0);
    chk("skid A held", bus.out_a, 32'hA);
    #1 drive(32'h00221820, 32'hC, 32'd1);
    @(negedge clk);
    chk("skid C blocked", bus.in_ready, 0);
    chk("skid A still", bus.out_a, 32'hA);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    chk("skid B out", bus.out_a, 32'hB);
    chk("skid ready back", bus.in_ready, 1);
    @(negedge clk);
    chk("skid C out", bus.out_a, 32'hC);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("skid drained", bus.out_valid, 0);

    // Reset while two beats are held.
    @(negedge clk); #1;
    bus.out_ready = 1'b0;
    drive(32'h00221820, 32'hD, 32'd1);
    @(negedge clk); #1;
    drive(32'h00221820, 32'hE, 32'd1);
    @(negedge clk);
    chk("two before rst", bus.in_ready, 0);
    #1;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst two valid", bus.out_valid, 0);
    chk("rst two ready", bus.in_ready, 1);
    @(negedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no stale beat", bus.out_valid, 0);
    end

    // Randomized traffic, with one reset in the middle.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk); #1;
      if (i == 700) rst_n = 1'b0;
      if (i == 702) rst_n = 1'b1;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_instr  = rand_instr();
      bus.in_rs_val = $urandom;
      bus.in_rt_val = $urandom;
      bus.out_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Execute-issue stage directly upstream of the 32-bit ALU. Accepts one MIPS-style ALU instruction plus its two register-file read values per beat. Decodes the instruction into the ALU's 4-bit `aluc` control and forms the `a`/`b` operands (immediate extension, shift amount, LUI), then holds the result in a registered two-entry skid buffer. A valid/ready handshake on both sides lets the ALU-plus-writeback stage stall without losing beats.

## Interface
- `XLEN`, 32, operand width; only 32 is legal, checked by an elaboration-time assertion.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream beat valid.
- `in_ready` out 1: stage can accept a beat.
- `in_instr` in 32: instruction word.
- `in_rs_val` in XLEN: value of register rs.
- `in_rt_val` in XLEN: value of register rt.
- `out_valid` out 1: issued beat valid.
- `out_ready` in 1: ALU stage accepts the beat.
- `out_a` out XLEN: ALU operand a.
- `out_b` out XLEN: ALU operand b.
- `out_aluc` out 4: ALU control.
- `out_dest` out 5: destination register.
- `out_wen` out 1: register write enable.
- `out_illegal` out 1: present only with the macro; beat was unsupported.
- `err_sticky` out 1: present only with the macro; set on the first illegal beat, cleared only by reset.

## Operation
- `aluc` encoding:
  - ADD 0000, SUB 0100
  - AND 0001, OR 0101
  - XOR 0010, LUI 0110
  - SLL 0011, SRL 0111, SRA 1111
- R-type instructions (opcode 000000), decoded by funct:
  - 100000/100001 → ADD; 100010/100011 → SUB
  - 100100 → AND; 100101 → OR; 100110 → XOR
  - Operands: a=rs, b=rt.
  - 000000/000010/000011 → SLL/SRL/SRA with a={27'b0,shamt}, b=rt.
  - 000100/000110/000111 → SLL/SRL/SRA with a=rs, b=rt; the ALU uses a[4:0] as the shift amount.
  - Destination is rd.
- I-type instructions:
  - 001000/001001 → ADD, b=sign-extended imm16.
  - 001100/001101/001110 → AND/OR/XOR, b=zero-extended imm16.
  - 001111 → LUI, b={16'b0,imm16}.
  - Operand a=rs. Destination is rt.
- `out_wen` = supported instruction AND destination ≠ 0. A write to r0 issues normally with wen=0.
- Unsupported opcode/funct: beat still issues with aluc=0000, a=rs, b=rt, dest=0, wen=0. It is never dropped.
- No overflow trap; add/addu and sub/subu decode identically.

## Timing
- Latency: 1 cycle from the accepted input beat to `out_valid`.
- Throughput: 1 beat/cycle while `out_ready`=1.
- Beat transfer: on any edge where valid&&ready is high on that port.
- `in_ready` = ~skid_full (registered). It never depends combinationally on `out_ready`.
- Storage: main register (drives outputs) + skid register. Three states:
  - EMPTY → ONE on an input accept.
  - ONE stays ONE on accept + output accept.
  - ONE → EMPTY on output accept with no input accept.
  - ONE → TWO on input accept while the output is stalled; the input beat goes to skid.
  - TWO → ONE on output accept; skid moves to main and `in_ready` rises the next cycle.
  - In TWO no input is accepted.
- Order is strictly FIFO. Output payload is stable while out_valid&&!out_ready.
- Reset (any time, including mid-transfer): state EMPTY; all beats discarded.
  - out_valid=0; out_a, out_b, out_aluc, out_dest, out_wen, out_illegal, err_sticky all 0; in_ready=1.
  - Payload registers need no reset beyond the zeroing above.

## Configuration
- `ALU_ISSUE_ILLEGAL_EN` defined:
  - `out_illegal` travels with each beat (1 for unsupported decodes).
  - `err_sticky` sets on the first issued illegal beat.
- Not defined: both ports and their logic are absent. Unsupported beats issue only as the wen=0 default.

## Structure
- Shared package `alu_pkg`:
  - `aluc` localparams (ALUC_ADD … ALUC_SRA).
  - Opcode/funct localparams.
  - Issue-beat struct typedef {a, b, aluc, dest, wen, illegal}.
- Sub-module `alu_issue_decode`: combinational decode of instr/rs/rt into the beat struct.
- The top module holds the skid buffer and handshake.

## Test plan
- Reset, then `add $3,$1,$2` (0x00221820) with rs=5, rt=7, out_ready=1 → one cycle later out_a=5, out_b=7, aluc=0000, dest=3, wen=1.
- `addi $4,$0,-1` (0x2004FFFF), rs=0 → out_b=0xFFFFFFFF, aluc=0000. `ori` with imm 0xFFFF → out_b=0x0000FFFF, aluc=0101. `lui` imm 0x1234 → out_b=0x00001234, aluc=0110.
- `sra $5,$6,4` (0x00062903), rt=0x80000000 → out_a=4, out_b=0x80000000, aluc=1111. `srav` with rs=0x25 → out_a=0x25.
- Back-to-back beats A,B,C with out_ready held 0 for 3 cycles:
  - A in main, B in skid, in_ready=0, C held upstream.
  - Release out_ready → A,B,C emerge in order with no loss or duplication.
- Reset asserted with the stage in TWO → out_valid=0 and in_ready=1 immediately; no stale beat appears after reset release.
- With the macro, funct 101010 → out_illegal=1, wen=0, err_sticky=1 until reset. A write to $0 (`add $0,$1,$2`) → wen=0, illegal=0.
